id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core. It sits directly upstream of the EX-stage forwarding unit and operand muxes.
- Captures decoded operands, register indices and control bits from ID, and presents them registered to EX.
- Supplies the ID/EX source-register indices and the is-load indication that the forwarding/hazard logic consumes.
- Implements hold, bubble insertion and flush, and counts inserted bubbles.

---
 rtl/id_ex_stage_reg_if.sv | 53 +++++
 rtl/id_ex_stage_reg.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded fields from ID (id_*) and their registered copies to EX (ex_*).
// The master side is the decoder and the EX consumer. The slave side is the pipeline register.
interface id_ex_stage_reg_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                id_valid;
  logic [XLEN-1:0]     id_pc;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic [4:0]          id_rd;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_imm;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_alu_src;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;
  logic                id_mem_to_reg;

  logic                ex_valid;
  logic [XLEN-1:0]     ex_pc;
  logic [4:0]          ex_rs1;
  logic [4:0]          ex_rs2;
  logic [4:0]          ex_rd;
  logic [XLEN-1:0]     ex_rs1_data;
  logic [XLEN-1:0]     ex_rs2_data;
  logic [XLEN-1:0]     ex_imm;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_alu_src;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_mem_to_reg;
  logic                ex_is_load;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_is_load
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_is_load
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush/hold/bubble control and a saturating bubble counter.
// Optional ID_EX_WB_BYPASS_EN: forwards the MEM/WB write into rs1/rs2 data on load and on hold.
module id_ex_stage_reg #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_reg_if.slave  stage,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE
  } act_e;

  localparam stage_t NOP = '0;

  stage_t            stage_q, stage_d;
  stage_t            id_fields;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  act_e              act;

`ifdef ID_EX_WB_BYPASS_EN
  function automatic logic wb_hit(input logic       we,
                                  input logic [4:0] wrd,
                                  input logic [4:0] idx);
    return we && (wrd != 5'd0) && (wrd == idx);
  endfunction
`else
  // The register file already writes before it is read, so WB forwarding is not needed here.
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
`endif

  always_comb begin
    id_fields.valid      = stage.id_valid;
    id_fields.pc         = stage.id_pc;
    id_fields.rs1        = stage.id_rs1;
    id_fields.rs2        = stage.id_rs2;
    id_fields.rd         = stage.id_rd;
    id_fields.rs1_data   = stage.id_rs1_data;
    id_fields.rs2_data   = stage.id_rs2_data;
    id_fields.imm        = stage.id_imm;
    id_fields.alu_op     = stage.id_alu_op;
    id_fields.alu_src    = stage.id_alu_src;
    id_fields.reg_write  = stage.id_reg_write;
    id_fields.mem_read   = stage.id_mem_read;
    id_fields.mem_write  = stage.id_mem_write;
    id_fields.mem_to_reg = stage.id_mem_to_reg;
  end

  // Fixed priority: flush > hold > bubble > load.
  always_comb begin
    if (flush)       act = ACT_FLUSH;
    else if (hold)   act = ACT_HOLD;
    else if (bubble) act = ACT_BUBBLE;
    else             act = ACT_LOAD;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    unique case (act)
      ACT_FLUSH: stage_d = NOP;
      ACT_BUBBLE: begin
        stage_d = NOP;
        if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
      ACT_HOLD: begin
`ifdef ID_EX_WB_BYPASS_EN
        // A long freeze can outlive the WB write, so refresh the held operands.
        if (wb_hit(wb_reg_write, wb_rd, stage_q.rs1)) stage_d.rs1_data = wb_data;
        if (wb_hit(wb_reg_write, wb_rd, stage_q.rs2)) stage_d.rs2_data = wb_data;
`endif
      end
      default: begin
        stage_d = id_fields;
        // An empty slot keeps its fields but is stripped of every state-changing control bit.
        if (!stage.id_valid) begin
          stage_d.reg_write  = 1'b0;
          stage_d.mem_read   = 1'b0;
          stage_d.mem_write  = 1'b0;
          stage_d.mem_to_reg = 1'b0;
        end
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_hit(wb_reg_write, wb_rd, stage.id_rs1)) stage_d.rs1_data = wb_data;
        if (wb_hit(wb_reg_write, wb_rd, stage.id_rs2)) stage_d.rs2_data = wb_data;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      stage_q      <= NOP;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stage.ex_valid      = stage_q.valid;
  assign stage.ex_pc         = stage_q.pc;
  assign stage.ex_rs1        = stage_q.rs1;
  assign stage.ex_rs2        = stage_q.rs2;
  assign stage.ex_rd         = stage_q.rd;
  assign stage.ex_rs1_data   = stage_q.rs1_data;
  assign stage.ex_rs2_data   = stage_q.rs2_data;
  assign stage.ex_imm        = stage_q.imm;
  assign stage.ex_alu_op     = stage_q.alu_op;
  assign stage.ex_alu_src    = stage_q.alu_src;
  assign stage.ex_reg_write  = stage_q.reg_write;
  assign stage.ex_mem_read   = stage_q.mem_read;
  assign stage.ex_mem_write  = stage_q.mem_write;
  assign stage.ex_mem_to_reg = stage_q.mem_to_reg;
  assign stage.ex_is_load    = stage_q.valid & stage_q.mem_read;
  assign bubble_cnt          = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, counter saturation, randomized model check.
module tb_id_ex_stage_reg;

`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } f_t;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        hold;
    logic        bubble;
    f_t          id;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    f_t    e;
    int    cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, hold, bubble, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt_s;

  int checks   = 0;
  int failures = 0;

  id_ex_stage_reg_if #(.XLEN(32), .ALU_OP_W(4)) bus ();
  id_ex_stage_reg_if #(.XLEN(32), .ALU_OP_W(4)) bus_s ();

  id_ex_stage_reg #(.XLEN(32), .ALU_OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stage(bus), .flush(flush), .hold(hold), .bubble(bubble),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance sharing the control inputs, used for saturation.
  id_ex_stage_reg #(.XLEN(32), .ALU_OP_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stage(bus_s), .flush(flush), .hold(hold), .bubble(bubble),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .bubble_cnt(bubble_cnt_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic f_t ld(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                            logic [4:0] rd, logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                            logic [3:0] op, logic src, logic rw, logic mr, logic mw, logic m2r);
    f_t f;
    f.valid = v; f.pc = pc; f.rs1 = rs1; f.rs2 = rs2; f.rd = rd; f.d1 = d1; f.d2 = d2;
    f.imm = imm; f.op = op; f.src = src; f.rw = rw; f.mr = mr; f.mw = mw; f.m2r = m2r;
    return f;
  endfunction

  function automatic stim_t st(logic r, logic fl, logic ho, logic bu, f_t id,
                               logic wrw, logic [4:0] wrd, logic [31:0] wdata);
    stim_t s;
    s.rst = r; s.flush = fl; s.hold = ho; s.bubble = bu; s.id = id;
    s.wrw = wrw; s.wrd = wrd; s.wdata = wdata;
    return s;
  endfunction

  function automatic vec_t mkv(string name, stim_t s, f_t e, int cnt);
    vec_t v;
    v.name = name; v.s = s; v.e = e; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(stim_t s);
    @(negedge clk);
    rst = s.rst; flush = s.flush; hold = s.hold; bubble = s.bubble;
    wb_reg_write = s.wrw; wb_rd = s.wrd; wb_data = s.wdata;
    bus.id_valid = s.id.valid;   bus.id_pc = s.id.pc;
    bus.id_rs1 = s.id.rs1;       bus.id_rs2 = s.id.rs2;       bus.id_rd = s.id.rd;
    bus.id_rs1_data = s.id.d1;   bus.id_rs2_data = s.id.d2;   bus.id_imm = s.id.imm;
    bus.id_alu_op = s.id.op;     bus.id_alu_src = s.id.src;   bus.id_reg_write = s.id.rw;
    bus.id_mem_read = s.id.mr;   bus.id_mem_write = s.id.mw;  bus.id_mem_to_reg = s.id.m2r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(string tag, f_t e, int cnt);
    check({tag, ".valid"},    32'(bus.ex_valid),      32'(e.valid));
    check({tag, ".pc"},       bus.ex_pc,              e.pc);
    check({tag, ".rs1"},      32'(bus.ex_rs1),        32'(e.rs1));
    check({tag, ".rs2"},      32'(bus.ex_rs2),        32'(e.rs2));
    check({tag, ".rd"},       32'(bus.ex_rd),         32'(e.rd));
    check({tag, ".rs1_data"}, bus.ex_rs1_data,        e.d1);
    check({tag, ".rs2_data"}, bus.ex_rs2_data,        e.d2);
    check({tag, ".imm"},      bus.ex_imm,             e.imm);
    check({tag, ".alu_op"},   32'(bus.ex_alu_op),     32'(e.op));
    check({tag, ".alu_src"},  32'(bus.ex_alu_src),    32'(e.src));
    check({tag, ".reg_wr"},   32'(bus.ex_reg_write),  32'(e.rw));
    check({tag, ".mem_rd"},   32'(bus.ex_mem_read),   32'(e.mr));
    check({tag, ".mem_wr"},   32'(bus.ex_mem_write),  32'(e.mw));
    check({tag, ".mem2reg"},  32'(bus.ex_mem_to_reg), 32'(e.m2r));
    check({tag, ".is_load"},  32'(bus.ex_is_load),    32'(e.valid & e.mr));
    check({tag, ".cnt"},      32'(bubble_cnt),        32'(cnt));
  endtask

  // Reference: what EX should hold after one edge, derived from the stage rules.
  function automatic f_t model_next(f_t cur, stim_t s);
    f_t n;
    n = cur;
    if (s.rst || s.flush) n = '0;
    else if (s.hold) begin
      if (BYP && s.wrw && s.wrd != 0 && s.wrd == cur.rs1) n.d1 = s.wdata;
      if (BYP && s.wrw && s.wrd != 0 && s.wrd == cur.rs2) n.d2 = s.wdata;
    end else if (s.bubble) n = '0;
    else begin
      n = s.id;
      if (!s.id.valid) begin n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; end
      if (BYP && s.wrw && s.wrd != 0 && s.wrd == s.id.rs1) n.d1 = s.wdata;
      if (BYP && s.wrw && s.wrd != 0 && s.wrd == s.id.rs2) n.d2 = s.wdata;
    end
    return n;
  endfunction

  function automatic int cnt_next(int c, stim_t s, int max);
    if (s.rst) return 0;
    if (!s.flush && !s.hold && s.bubble) return (c < max) ? c + 1 : max;
    return c;
  endfunction

  initial begin
    vec_t  tbl[$];
    f_t    a, b, c, d, e, nop, hw, lw;
    f_t    m;
    stim_t s;
    int    mc, mc4;

    bus_s.id_valid = 0;    bus_s.id_pc = 0;       bus_s.id_rs1 = 0;      bus_s.id_rs2 = 0;
    bus_s.id_rd = 0;       bus_s.id_rs1_data = 0; bus_s.id_rs2_data = 0; bus_s.id_imm = 0;
    bus_s.id_alu_op = 0;   bus_s.id_alu_src = 0;  bus_s.id_reg_write = 0;
    bus_s.id_mem_read = 0; bus_s.id_mem_write = 0; bus_s.id_mem_to_reg = 0;

    nop = '0;
    a = ld(1, 32'h100, 5, 6, 7, 32'h11, 32'h22, 32'h4, 4'h3, 1, 1, 1, 0, 0);
    b = ld(1, 32'h104, 1, 2, 9, 32'h33, 32'h44, 32'h8, 4'h1, 0, 1, 0, 0, 0);
    c = ld(1, 32'h200, 8, 3, 10, 32'hAAAA, 32'hBBBB, 32'hFFFF_FFF0, 4'h7, 0, 1, 0, 1, 0);
    d = ld(1, 32'h304, 12, 3, 0, 32'h55, 32'h66, 32'h0, 4'h0, 0, 1, 0, 0, 0);
    e = ld(1, 32'h308, 12, 13, 14, 32'h1, 32'h2, 32'hC, 4'h5, 1, 1, 0, 0, 1);
    hw = d; if (BYP) hw.d2 = 32'hDEAD;
    lw = e; if (BYP) lw.d1 = 32'hCAFE;

    tbl.push_back(mkv("rst0",     st(1, 0, 0, 0, a, 0, 0, 0), nop, 0));
    tbl.push_back(mkv("rst1",     st(1, 1, 1, 1, a, 1, 5, 32'h9), nop, 0));
    tbl.push_back(mkv("load",     st(0, 0, 0, 0, a, 0, 0, 0), a, 0));
    tbl.push_back(mkv("bubble",   st(0, 0, 0, 1, b, 0, 0, 0), nop, 1));
    tbl.push_back(mkv("resume",   st(0, 0, 0, 0, b, 0, 0, 0), b, 1));
    tbl.push_back(mkv("fl_ho_bu", st(0, 1, 1, 1, a, 0, 0, 0), nop, 1));
    tbl.push_back(mkv("load_c",   st(0, 0, 0, 0, c, 0, 0, 0), c, 1));
    tbl.push_back(mkv("hold_bub", st(0, 0, 1, 1, a, 0, 0, 0), c, 1));
    tbl.push_back(mkv("invalid",
      st(0, 0, 0, 0, ld(0, 32'h300, 4, 5, 6, 1, 2, 3, 4'h2, 1, 1, 1, 1, 1), 0, 0, 0),
      ld(0, 32'h300, 4, 5, 6, 1, 2, 3, 4'h2, 1, 0, 0, 0, 0), 1));
    tbl.push_back(mkv("rd0_rw",   st(0, 0, 0, 0, d, 0, 0, 0), d, 1));
    tbl.push_back(mkv("hold_wb",  st(0, 0, 1, 0, a, 1, 3, 32'hDEAD), hw, 1));
    tbl.push_back(mkv("hold_wb0", st(0, 0, 1, 0, a, 1, 0, 32'hBEEF), hw, 1));
    tbl.push_back(mkv("load_wb",  st(0, 0, 0, 0, e, 1, 12, 32'hCAFE), lw, 1));
    tbl.push_back(mkv("flush_wb", st(0, 1, 0, 0, e, 1, 12, 32'hCAFE), nop, 1));

    foreach (tbl[i]) begin
      apply(tbl[i].s);
      check_state(tbl[i].name, tbl[i].e, tbl[i].cnt);
    end

    // Saturation: 20 back-to-back bubbles on both counter widths.
    apply(st(1, 0, 0, 0, a, 0, 0, 0));
    check("sat_rst", 32'(bubble_cnt_s), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      apply(st(0, 0, 0, 1, a, 0, 0, 0));
      check($sformatf("sat4_%0d", k), 32'(bubble_cnt_s), 32'((k < 15) ? k : 15));
      check($sformatf("cnt16_%0d", k), 32'(bubble_cnt), 32'(k));
    end
    apply(st(0, 0, 0, 0, a, 0, 0, 0));
    check("sat4_after", 32'(bubble_cnt_s), 32'd15);
    check_state("post_sat", a, 20);

    // Randomized run against the reference model.
    apply(st(1, 0, 0, 0, a, 0, 0, 0));
    m = '0; mc = 0; mc4 = 0;
    for (int n = 0; n < 600; n++) begin
      s.rst    = ($urandom_range(99) < 2);
      s.flush  = ($urandom_range(99) < 10);
      s.hold   = ($urandom_range(99) < 25);
      s.bubble = ($urandom_range(99) < 25);
      s.id.valid = ($urandom_range(99) < 80);
      s.id.pc  = $urandom;
      s.id.rs1 = 5'($urandom_range(7));
      s.id.rs2 = 5'($urandom_range(7));
      s.id.rd  = 5'($urandom);
      s.id.d1  = $urandom;
      s.id.d2  = $urandom;
      s.id.imm = $urandom;
      s.id.op  = 4'($urandom);
      {s.id.src, s.id.rw, s.id.mr, s.id.mw, s.id.m2r} = 5'($urandom);
      s.wrw   = 1'($urandom);
      s.wrd   = 5'($urandom_range(7));
      s.wdata = $urandom;
      apply(s);
      m   = model_next(m, s);
      mc  = cnt_next(mc, s, 65535);
      mc4 = cnt_next(mc4, s, 15);
      check_state($sformatf("rnd%0d", n), m, mc);
      check($sformatf("rnd%0d.cnt4", n), 32'(bubble_cnt_s), 32'(mc4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
